// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-memory port arbiter: bus commands and request ownership.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } MEM_OWNER;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the I-cache, D-cache and memory-side signals of the arbiter.
// master = arbiter view, slave = the surrounding caches and memory.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
);
    BUS_COMMAND         ic_command;
    logic [XLEN-1:0]    ic_addr;
    logic [TAG_W-1:0]   ic_accept_tag;
    logic [TAG_W-1:0]   ic_resp_tag;
    logic [63:0]        ic_resp_data;

    BUS_COMMAND         dc_command;
    logic [XLEN-1:0]    dc_addr;
    logic [63:0]        dc_data;
    logic [TAG_W-1:0]   dc_accept_tag;
    logic [TAG_W-1:0]   dc_resp_tag;
    logic [63:0]        dc_resp_data;

    BUS_COMMAND         proc2mem_command;
    logic [XLEN-1:0]    proc2mem_addr;
    logic [63:0]        proc2mem_data;
    logic [TAG_W-1:0]   mem2proc_response;
    logic [63:0]        mem2proc_data;
    logic [TAG_W-1:0]   mem2proc_tag;

    logic [TAG_W-1:0]   outstanding_cnt;
    logic               orphan_err;

    modport master (
        input  ic_command, ic_addr, dc_command, dc_addr, dc_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output ic_accept_tag, ic_resp_tag, ic_resp_data,
        output dc_accept_tag, dc_resp_tag, dc_resp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output outstanding_cnt, orphan_err
    );

    modport slave (
        output ic_command, ic_addr, dc_command, dc_addr, dc_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ic_accept_tag, ic_resp_tag, ic_resp_data,
        input  dc_accept_tag, dc_resp_tag, dc_resp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  outstanding_cnt, orphan_err
    );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// Tracks which requester owns each in-flight load tag, plus a count of live entries.
// One allocation port and one lookup/retire port; allocation wins a same-tag write.
module mem_bus_arbiter_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alloc_en,
    input  logic [TAG_W-1:0]   alloc_tag,
    input  MEM_OWNER           alloc_owner,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               lookup_hit,
    output MEM_OWNER           lookup_owner,
    output logic               alloc_clash,
    output logic [TAG_W-1:0]   cnt
);
    localparam int unsigned Entries = 2 ** TAG_W;

    logic [Entries-1:0] valid_q, valid_d;
    MEM_OWNER           owner_q [Entries];
    MEM_OWNER           owner_d [Entries];
    logic [TAG_W-1:0]   cnt_q, cnt_d;
    logic               add_entry;

    always_comb begin
        lookup_hit   = (lookup_tag != '0) && valid_q[lookup_tag];
        lookup_owner = owner_q[lookup_tag];
        // A live tag being retired this same cycle is a legal reuse, not a clash.
        alloc_clash  = alloc_en && valid_q[alloc_tag] &&
                       !(lookup_hit && (lookup_tag == alloc_tag));
        add_entry    = alloc_en && !alloc_clash;

        valid_d = valid_q;
        owner_d = owner_q;
        if (lookup_hit) begin
            valid_d[lookup_tag] = 1'b0;
        end
        if (alloc_en) begin
            valid_d[alloc_tag] = 1'b1;
            owner_d[alloc_tag] = alloc_owner;
        end

        cnt_d = cnt_q + {{(TAG_W-1){1'b0}}, add_entry} - {{(TAG_W-1){1'b0}}, lookup_hit};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < Entries; i++) begin
                owner_q[i] <= OWNER_IC;
            end
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between I-cache fetch and D-cache, muxing one request per
// cycle and routing tagged load completions back to whichever side issued them.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 4,
    parameter bit          DC_FIXED = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    mem_bus_arbiter_if.master  bus
);
    MEM_OWNER           rr_q, rr_d;
    logic               orphan_q, orphan_d;

    logic               ic_act, dc_act, sel_dc, req_act, accepted, alloc_en;
    BUS_COMMAND         sel_cmd;
    logic [XLEN-1:0]    sel_addr;
    logic [63:0]        sel_data;
    logic [TAG_W-1:0]   ic_acc, dc_acc, ic_resp, dc_resp;
    logic               lookup_hit, alloc_clash;
    MEM_OWNER           lookup_owner;
    logic [TAG_W-1:0]   cnt;

    always_comb begin
        // An I-cache store is illegal and simply never forwarded.
        ic_act   = (bus.ic_command == BUS_LOAD);
        dc_act   = (bus.dc_command == BUS_LOAD) || (bus.dc_command == BUS_STORE);
        sel_dc   = dc_act && (!ic_act || DC_FIXED || (rr_q == OWNER_DC));
        req_act  = (ic_act || dc_act) && !reset;
        accepted = req_act && (bus.mem2proc_response != '0);

        sel_cmd  = BUS_NONE;
        sel_addr = '0;
        sel_data = '0;
        if (req_act) begin
            if (sel_dc) begin
                sel_cmd  = bus.dc_command;
                sel_addr = bus.dc_addr;
                sel_data = bus.dc_data;
            end else begin
                sel_cmd  = BUS_LOAD;
                sel_addr = bus.ic_addr;
            end
        end
        alloc_en = accepted && (sel_cmd == BUS_LOAD);

        ic_acc = (req_act && !sel_dc) ? bus.mem2proc_response : '0;
        dc_acc = (req_act &&  sel_dc) ? bus.mem2proc_response : '0;

        ic_resp = '0;
        dc_resp = '0;
        if (lookup_hit && !reset) begin
            if (lookup_owner == OWNER_DC) begin
                dc_resp = bus.mem2proc_tag;
            end else begin
                ic_resp = bus.mem2proc_tag;
            end
        end

        // Pointer only moves on an accepted contested request, so a rejected pick stays put.
        rr_d = rr_q;
        if (accepted && ic_act && dc_act) begin
            rr_d = sel_dc ? OWNER_IC : OWNER_DC;
        end

        orphan_d = orphan_q || alloc_clash || ((bus.mem2proc_tag != '0) && !lookup_hit);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q     <= OWNER_IC;
            orphan_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            orphan_q <= orphan_d;
        end
    end

    mem_bus_arbiter_tag_table #(
        .TAG_W (TAG_W)
    ) u_tag_table (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_tag    (bus.mem2proc_response),
        .alloc_owner  (sel_dc ? OWNER_DC : OWNER_IC),
        .lookup_tag   (bus.mem2proc_tag),
        .lookup_hit   (lookup_hit),
        .lookup_owner (lookup_owner),
        .alloc_clash  (alloc_clash),
        .cnt          (cnt)
    );

    assign bus.proc2mem_command = sel_cmd;
    assign bus.proc2mem_addr    = sel_addr;
    assign bus.proc2mem_data    = sel_data;
    assign bus.ic_accept_tag    = ic_acc;
    assign bus.dc_accept_tag    = dc_acc;
    assign bus.ic_resp_tag      = ic_resp;
    assign bus.dc_resp_tag      = dc_resp;
    assign bus.ic_resp_data     = bus.mem2proc_data;
    assign bus.dc_resp_data     = bus.mem2proc_data;
    assign bus.outstanding_cnt  = cnt;
    assign bus.orphan_err       = orphan_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: outstanding loads kept in a scoreboard queue,
// popped and compared when the memory side reports their completion.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        logic [3:0] tag;
        logic       dc_owner;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic rr_m     = 1'b0;
    logic orphan_m = 1'b0;

    mem_bus_arbiter_if #(.XLEN(32), .TAG_W(4)) bus ();

    mem_bus_arbiter #(
        .XLEN     (32),
        .TAG_W    (4),
        .DC_FIXED (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_tag(input logic [3:0] t);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic drive_idle();
        bus.ic_command        = BUS_NONE;
        bus.ic_addr           = '0;
        bus.dc_command        = BUS_NONE;
        bus.dc_addr           = '0;
        bus.dc_data           = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    // Reset with requests active and a completion present: outputs must be quiet throughout.
    task automatic do_reset();
        @(negedge clock);
        bus.ic_command        = BUS_LOAD;
        bus.dc_command        = BUS_LOAD;
        bus.mem2proc_response = 4'd5;
        bus.mem2proc_tag      = 4'd1;
        reset = 1'b1;
        #1;
        check_eq("rst_cnt",      bus.outstanding_cnt,  0);
        check_eq("rst_cmd",      bus.proc2mem_command, BUS_NONE);
        check_eq("rst_ic_acc",   bus.ic_accept_tag,    0);
        check_eq("rst_dc_acc",   bus.dc_accept_tag,    0);
        check_eq("rst_ic_resp",  bus.ic_resp_tag,      0);
        check_eq("rst_dc_resp",  bus.dc_resp_tag,      0);
        check_eq("rst_orphan",   bus.orphan_err,       0);
        @(negedge clock);
        drive_idle();
        reset = 1'b0;
        exp_q.delete();
        rr_m     = 1'b0;
        orphan_m = 1'b0;
    endtask

    task automatic step(input BUS_COMMAND ic_c, input logic [31:0] ic_a,
                        input BUS_COMMAND dc_c, input logic [31:0] dc_a, input logic [63:0] dc_d,
                        input logic [3:0] resp, input logic [3:0] ctag);
        logic       ic_act, dc_act, sel_dc, any_act;
        BUS_COMMAND e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data, mdata;
        logic [3:0] e_ic_acc, e_dc_acc, e_ic_resp, e_dc_resp;
        int         hit, dup;

        mdata = {$urandom, $urandom};
        bus.ic_command        = ic_c;
        bus.ic_addr           = ic_a;
        bus.dc_command        = dc_c;
        bus.dc_addr           = dc_a;
        bus.dc_data           = dc_d;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = ctag;
        bus.mem2proc_data     = mdata;
        #1;

        ic_act  = (ic_c == BUS_LOAD);
        dc_act  = (dc_c == BUS_LOAD) || (dc_c == BUS_STORE);
        sel_dc  = dc_act && (!ic_act || rr_m);
        any_act = ic_act || dc_act;
        e_cmd    = !any_act ? BUS_NONE : (sel_dc ? dc_c : BUS_LOAD);
        e_addr   = !any_act ? 32'h0 : (sel_dc ? dc_a : ic_a);
        e_data   = (any_act && sel_dc) ? dc_d : 64'h0;
        e_ic_acc = (any_act && !sel_dc) ? resp : 4'h0;
        e_dc_acc = (any_act && sel_dc) ? resp : 4'h0;

        hit = (ctag != 0) ? find_tag(ctag) : -1;
        e_ic_resp = 4'h0;
        e_dc_resp = 4'h0;
        if (hit >= 0) begin
            if (exp_q[hit].dc_owner) e_dc_resp = ctag;
            else                     e_ic_resp = ctag;
        end

        check_eq("cmd",     bus.proc2mem_command, e_cmd);
        check_eq("addr",    bus.proc2mem_addr,    e_addr);
        check_eq("data",    bus.proc2mem_data,    e_data);
        check_eq("ic_acc",  bus.ic_accept_tag,    e_ic_acc);
        check_eq("dc_acc",  bus.dc_accept_tag,    e_dc_acc);
        check_eq("ic_resp", bus.ic_resp_tag,      e_ic_resp);
        check_eq("dc_resp", bus.dc_resp_tag,      e_dc_resp);
        check_eq("ic_rdat", bus.ic_resp_data,     mdata);
        check_eq("dc_rdat", bus.dc_resp_data,     mdata);
        check_eq("cnt",     bus.outstanding_cnt,  64'(exp_q.size()));
        check_eq("orphan",  bus.orphan_err,       orphan_m);

        @(posedge clock);
        if (hit >= 0)       exp_q.delete(hit);
        else if (ctag != 0) orphan_m = 1'b1;
        if (any_act && resp != 0) begin
            if (e_cmd == BUS_LOAD) begin
                dup = find_tag(resp);
                if (dup >= 0) begin
                    orphan_m = 1'b1;
                    exp_q.delete(dup);
                end
                exp_q.push_back('{tag: resp, dc_owner: sel_dc});
            end
            if (ic_act && dc_act) rr_m = !sel_dc;
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic [3:0] ctag);
        step(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, ctag);
    endtask

    initial begin
        drive_idle();
        do_reset();

        // Lone I-cache load, then its completion.
        step(BUS_LOAD, 32'h100, BUS_NONE, 32'h0, 64'h0, 4'd3, 4'd0);
        idle(4'd0);
        idle(4'd3);
        idle(4'd0);

        // Contention: IC first by pointer, then DC.
        step(BUS_LOAD, 32'h108, BUS_LOAD, 32'h300, 64'h0, 4'd5, 4'd0);
        step(BUS_LOAD, 32'h110, BUS_LOAD, 32'h300, 64'h0, 4'd6, 4'd0);
        idle(4'd6);
        idle(4'd5);

        // Rejections hold the selection steady.
        for (int i = 0; i < 3; i++) begin
            step(BUS_LOAD, 32'h118, BUS_LOAD, 32'h308, 64'h0, 4'd0, 4'd0);
        end
        step(BUS_LOAD, 32'h118, BUS_LOAD, 32'h308, 64'h0, 4'd8, 4'd0);
        step(BUS_NONE, 32'h0,   BUS_LOAD, 32'h308, 64'h0, 4'd9, 4'd0);
        idle(4'd8);
        idle(4'd9);

        // I-cache store is never forwarded.
        step(BUS_STORE, 32'h400, BUS_NONE, 32'h0, 64'h0, 4'd5, 4'd0);

        // Same-cycle retire and reuse of tag 4.
        step(BUS_LOAD, 32'h120, BUS_NONE, 32'h0, 64'h0, 4'd4, 4'd0);
        step(BUS_NONE, 32'h0,   BUS_LOAD, 32'h310, 64'h0, 4'd4, 4'd4);
        idle(4'd0);
        idle(4'd4);

        // Store is untracked; its tag completing is an orphan.
        step(BUS_NONE, 32'h0, BUS_STORE, 32'h200, 64'hDEADBEEF, 4'd7, 4'd0);
        idle(4'd0);
        idle(4'd7);
        idle(4'd0);

        // Reset with loads in flight; a stale completion afterwards is an orphan.
        step(BUS_LOAD, 32'h128, BUS_NONE, 32'h0,   64'h0, 4'd1, 4'd0);
        step(BUS_NONE, 32'h0,   BUS_LOAD, 32'h318, 64'h0, 4'd2, 4'd0);
        step(BUS_NONE, 32'h0,   BUS_LOAD, 32'h320, 64'h0, 4'd3, 4'd0);
        idle(4'd0);
        do_reset();
        idle(4'd2);
        idle(4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
